// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Provides the FSM state enum, digit width/limit and a result-width helper.
package bcd_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    // Smallest result width able to hold 10^digits - 1.
    function automatic int min_out_w(input int digits);
        longint lim;
        lim = 1;
        for (int i = 0; i < digits; i++) begin
            lim = lim * 10;
        end
        return $clog2(lim);
    endfunction

endpackage

// File: rtl/bcd_mul10_add.sv
// Combinational accumulate step: y = (acc*10 + digit) mod 2^OUT_W.
// Ports: acc (OUT_W) running value, digit (4) next digit, y (OUT_W) result.
module bcd_mul10_add
    import bcd_pkg::*;
#(
    parameter int OUT_W = 14
) (
    input  logic [OUT_W-1:0]       acc,
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [OUT_W-1:0]       y
);

    localparam int W = OUT_W + BCD_DIGIT_W;

    logic [W-1:0] acc_w;

    assign acc_w = {{BCD_DIGIT_W{1'b0}}, acc};

    // x10 as x8 + x2 at the widened width, then truncate.
    assign y = OUT_W'((acc_w << 3) + (acc_w << 1) + W'(digit));

endmodule

// File: rtl/bcd_binary_converter.sv
// Sequential BCD-to-binary converter, one digit per cycle, MSD first.
// Ports: clk, rst (sync, active high), bcd_in, start -> busy, done, result, err.
// Optional macro BCD_RANGE_CHECK_EN rejects digits above 9 (err=1, result=0).
module bcd_binary_converter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*DIGITS-1:0]       bcd_in,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [OUT_W-1:0]          result,
    output logic                      err
);

    localparam int SR_W  = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             state;
    logic [SR_W-1:0]    sr;
    logic [OUT_W-1:0]   acc;
    logic [OUT_W-1:0]   acc_nxt;
    logic [CNT_W-1:0]   cnt;

    bcd_mul10_add #(
        .OUT_W (OUT_W)
    ) u_mul10_add (
        .acc   (acc),
        .digit (sr[SR_W-1 -: BCD_DIGIT_W]),
        .y     (acc_nxt)
    );

`ifdef BCD_RANGE_CHECK_EN
    logic in_bad;
    logic bad_q;

    always_comb begin
        in_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W] >
                BCD_DIGIT_W'(BCD_MAX)) begin
                in_bad = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            result <= '0;
            acc    <= '0;
            sr     <= '0;
            cnt    <= '0;
`ifdef BCD_RANGE_CHECK_EN
            bad_q  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sr    <= bcd_in;
                        acc   <= '0;
                        cnt   <= CNT_W'(DIGITS - 1);
                        busy  <= 1'b1;
                        state <= RUN;
`ifdef BCD_RANGE_CHECK_EN
                        bad_q <= in_bad;
`endif
                    end
                end
                RUN: begin
`ifdef BCD_RANGE_CHECK_EN
                    // Invalid input finishes one cycle after start.
                    if (bad_q) begin
                        result <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else
`endif
                    begin
                        acc <= acc_nxt;
                        sr  <= sr << BCD_DIGIT_W;
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) begin
                            result <= acc_nxt;
                            err    <= 1'b0;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_binary_converter.sv
// Self-checking bench for bcd_binary_converter (default and DIGITS=3 builds).
// Table vectors, random vectors vs. arithmetic model, handshake corner cases.
module tb_bcd_binary_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bcd_in;
    logic        start;
    logic        busy, done, err;
    logic [13:0] result;

    logic        rst3;
    logic [11:0] bcd3;
    logic        start3;
    logic        busy3, done3, err3;
    logic [9:0]  res3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bcd_binary_converter #(.DIGITS(4), .OUT_W(14)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .start(start),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    bcd_binary_converter #(.DIGITS(3), .OUT_W(10)) dut3 (
        .clk(clk), .rst(rst3), .bcd_in(bcd3), .start(start3),
        .busy(busy3), .done(done3), .result(res3), .err(err3)
    );

    typedef struct {
        logic [15:0] bcd;
        int          res;
        int          er;
        int          lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Value = sum of digit * 10^position, modulo 2^14.
    function automatic void model(input logic [15:0] b, output int v,
                                  output int bad, output int lat);
        int pw;
        v   = 0;
        bad = 0;
        pw  = 1;
        for (int i = 0; i < 4; i++) begin
            int d;
            d = int'(b[i*4 +: 4]);
            if (d > 9) bad = 1;
            v  = v + d * pw;
            pw = pw * 10;
        end
        v   = v % 16384;
        lat = 4;
`ifdef BCD_RANGE_CHECK_EN
        if (bad == 1) begin
            v   = 0;
            lat = 1;
        end
`else
        bad = 0;
`endif
    endfunction

    task automatic convert(input string name, input logic [15:0] b,
                           input int exp_res, input int exp_er,
                           input int exp_lat);
        int lat;
        bcd_in = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({name, ".busy0"}, int'(busy), 1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        check({name, ".lat"}, lat, exp_lat);
        check({name, ".res"}, int'(result), exp_res);
        check({name, ".err"}, int'(err), exp_er);
        check({name, ".busy_end"}, int'(busy), 0);
        tick();
        check({name, ".done_pulse"}, int'(done), 0);
    endtask

    initial begin
        vec_t vt[7];
        int   v, bad, lat, dn;
        logic [15:0] b;

        vt[0] = '{16'h1234, 1234, 0, 4};
        vt[1] = '{16'h9999, 9999, 0, 4};
        vt[2] = '{16'h0000,    0, 0, 4};
        vt[3] = '{16'h0042,   42, 0, 4};
        vt[4] = '{16'h9000, 9000, 0, 4};
        vt[5] = '{16'h0001,    1, 0, 4};
`ifdef BCD_RANGE_CHECK_EN
        vt[6] = '{16'h12A4,    0, 1, 1};
`else
        vt[6] = '{16'h12A4, 1304, 0, 4};
`endif

        rst = 1'b1; start = 1'b0; bcd_in = '0;
        rst3 = 1'b1; start3 = 1'b0; bcd3 = '0;
        tick(); tick();
        rst = 1'b0; rst3 = 1'b0;
        check("rst.busy", int'(busy), 0);
        check("rst.done", int'(done), 0);
        check("rst.err", int'(err), 0);
        check("rst.result", int'(result), 0);

        for (int i = 0; i < 7; i++) begin
            convert($sformatf("vec%0d", i), vt[i].bcd, vt[i].res,
                    vt[i].er, vt[i].lat);
        end

        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) begin
                for (int j = 0; j < 4; j++) begin
                    b[j*4 +: 4] = 4'($urandom_range(0, 9));
                end
            end else begin
                b = 16'($urandom);
            end
            model(b, v, bad, lat);
            convert($sformatf("rnd%0d", i), b, v, bad, lat);
        end

        // Back-to-back: second start in the done cycle.
        bcd_in = 16'h9999;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        dn = 0;
        for (int k = 1; k <= 10 && dn == 0; k++) begin
            tick();
            if (done) dn = k;
        end
        check("b2b.first_lat", dn, 4);
        check("b2b.first_res", int'(result), 9999);
        bcd_in = 16'h0000;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        dn = 0;
        for (int k = 1; k <= 10 && dn == 0; k++) begin
            tick();
            if (done) dn = k + 1;
        end
        check("b2b.gap", dn, 5);
        check("b2b.second_res", int'(result), 0);

        // Start reasserted while busy with changed input.
        bcd_in = 16'h1234;
        start  = 1'b1;
        tick();
        bcd_in = 16'h5555;
        tick(); tick(); tick();
        start  = 1'b0;
        dn = int'(done);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) dn++;
            if (done) check("ign.res", int'(result), 1234);
        end
        check("ign.done_count", dn, 1);
        check("ign.busy_idle", int'(busy), 0);

        // Reset during RUN aborts.
        bcd_in = 16'h1234;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy", int'(busy), 0);
        check("abort.result", int'(result), 0);
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) dn++;
        end
        check("abort.no_done", dn, 0);
        convert("after_abort", 16'h0042, 42, 0, 4);

        // Three-digit build.
        bcd3   = 12'h999;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        dn = 0;
        for (int k = 1; k <= 10 && dn == 0; k++) begin
            tick();
            if (done3) dn = k;
        end
        check("d3.lat", dn, 3);
        check("d3.res", int'(res3), 999);
        check("d3.err", int'(err3), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
